iob_uart_host: RTL and testbench
================================

Name: iob_uart_host

Overview:
- IOb native initiator that drives the UART peripheral's register interface from the host side.
- Brings the UART up: soft reset, divisor, TX enable, and RX enable when compiled in.
- Moves bytes from a valid/ready byte stream into TXDATA, polling TXREADY first.
- Sits between a hardware byte producer/consumer (no CPU) and the UART's iob_s port. One transaction outstanding at a time.

Parameters:
ADDR_W, 16, IOb address width (word address)
DATA_W, 32, IOb data width
DIV_W, 16, divisor width
POLL_GAP, 4, idle cycles inserted after a not-ready status poll (0 = back-to-back)
SOFTRESET_ADDR, 0, word address of SOFTRESET
DIV_ADDR, 1, word address of DIV
TXDATA_ADDR, 2, word address of TXDATA
TXEN_ADDR, 3, word address of TXEN
TXREADY_ADDR, 4, word address of TXREADY
RXEN_ADDR, 5, word address of RXEN
RXREADY_ADDR, 6, word address of RXREADY
RXDATA_ADDR, 7, word address of RXDATA

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
cfg_i  in  1  pulse: re-run init sequence
div_i  in  DIV_W  bit duration written to DIV during init
init_done_o  out  1  high once init sequence completes
tx_data_i  in  8  byte to send
tx_valid_i  in  1  byte valid
tx_ready_o  out  1  holding register empty
iob_valid_o  out  1  request valid
iob_addr_o  out  ADDR_W  word address
iob_wdata_o  out  DATA_W  write data, LSB-aligned
iob_wstrb_o  out  DATA_W/8  all ones on writes, zero on reads
iob_rvalid_i  in  1  read data valid
iob_rdata_i  in  DATA_W  read data
iob_ready_i  in  1  request accepted

Behaviour:
- Reset (rst_n_i low at a clk_i edge) forces the following, and aborts any in-flight transaction; the bus valid drops the next cycle:
  - iob_valid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0
  - init_done_o=0, tx_ready_o=0
  - holding register empty
  - FSM=INIT_SRST1
- After reset release: tx_ready_o=1 from the first cycle.
- Bus rule:
  - iob_valid_o, iob_addr_o, iob_wdata_o and iob_wstrb_o are held stable until iob_ready_i=1.
  - A write completes on the valid&ready cycle.
  - A read completes on the first cycle with iob_rvalid_i=1, at or after ready. rdata is sampled on that cycle.
  - The next request is issued no earlier than the cycle after completion.
- FSM:
  - INIT_SRST1: write 1 to SOFTRESET.
  - INIT_SRST0: write 0 to SOFTRESET.
  - INIT_DIV: write zero-extended div_i, sampled at state entry.
  - INIT_TXEN: write 1 to TXEN.
  - Then IDLE; init_done_o=1 from IDLE entry.
  - IDLE: holding register full -> POLL_TX.
  - POLL_TX: read TXREADY.
    - rdata[0]=1 -> WR_TX.
    - rdata[0]=0 -> GAP.
  - WR_TX: write the held byte to TXDATA. On completion, the holding register empties and the FSM returns to IDLE.
  - GAP: wait POLL_GAP cycles (counter), then IDLE. POLL_GAP=0 skips GAP.
- Holding register:
  - tx_valid_i&tx_ready_o captures tx_data_i; tx_ready_o=0 the next cycle.
  - tx_ready_o=1 the cycle after WR_TX completes.
  - No same-cycle refill.
  - Bytes may be accepted during init.
- cfg_i:
  - In IDLE or GAP: enter INIT_SRST1 next cycle.
  - During a transaction: latched, applied after completion, never cutting a handshake.
  - init_done_o=0 while re-initialising.
  - A held byte survives and is sent after re-init.
  - cfg_i during init restarts the sequence after the current transaction.
- Stalls: no timeout. A responder that never asserts ready or rvalid stalls the FSM indefinitely.

Optional Feature:
- Macro: IOB_UART_HOST_RX_EN.
- With the macro:
  - Adds ports rx_data_o[8] out, rx_valid_o out, rx_ready_i in.
  - Init adds INIT_RXEN (write 1 to RXEN) after INIT_TXEN.
  - IDLE alternates round-robin between TX and RX service, TX first after init. Each side is serviced only if TX holding is full (TX side) or the RX output register is empty (RX side).
  - POLL_RX reads RXREADY. 1 -> RD_RX; 0 -> GAP.
  - RD_RX reads RXDATA and captures rdata[7:0] into rx_data_o with rx_valid_o=1. It holds until rx_valid_o&rx_ready_i; rx_valid_o=0 the next cycle.
  - Reset: rx_valid_o=0, rx_data_o=0.
- Without the macro: no RX ports, no RXEN write, and RX addresses are unused.

Decomposition:
- Package iob_uart_host_pkg: FSM state encoding, default register word addresses, IOB_UART_HOST_WSTRB_ALL constant.
- Sub-module iob_uart_host_txn: single-transaction engine.
  - Inputs: start, we, addr, wdata.
  - Outputs: done, rdata, plus the IOb master pins.
  - Implements the hold-until-ready / wait-for-rvalid rule. The main FSM only sequences it.

Test Plan:
- Reset release, DIV input=434, ready and rvalid always 1:
  - writes appear in order: SOFTRESET=1, SOFTRESET=0, DIV=434, TXEN=1
  - init_done_o=1 the cycle after the TXEN handshake.
- Send 0x55, responder returns TXREADY 0, 0, 1, POLL_GAP=4:
  - three TXREADY reads, 4-cycle gaps after the first two
  - one TXDATA write with wdata=0x55
  - tx_ready_o returns to 1 after the write.
- Responder holds iob_ready_i low 5 cycles on the TXDATA write:
  - iob_valid_o, addr and wdata are stable all 5 cycles
  - the second byte 0xA3 is not accepted (tx_ready_o=0) until completion.
- Pulse cfg_i mid-poll with byte 0x7E held:
  - the poll completes, then the full init sequence runs
  - 0x7E is then written to TXDATA.
- Assert rst_n_i low with iob_valid_o=1 and the request not yet accepted:
  - next cycle iob_valid_o=0, tx_ready_o=0, init_done_o=0
  - after release the init sequence restarts from SOFTRESET=1.
- (RX_EN) RXREADY=1, RXDATA=0xC4, rx_ready_i held low:
  - rx_data_o=0xC4, rx_valid_o=1
  - no further RX polls until rx_ready_i=1; TX service continues.

Source files
------------

// File: rtl/iob_uart_host_pkg.sv
// Shared types and constants for the IOb UART host: FSM state encoding,
// default UART register word addresses and the full write-strobe constant.
package iob_uart_host_pkg;

    typedef enum logic [3:0] {
        ST_INIT_SRST1,
        ST_INIT_SRST0,
        ST_INIT_DIV,
        ST_INIT_TXEN,
        ST_INIT_RXEN,
        ST_IDLE,
        ST_POLL_TX,
        ST_WR_TX,
        ST_GAP,
        ST_POLL_RX,
        ST_RD_RX
    } state_t;

    localparam int IOB_UART_HOST_DATA_W = 32;
    localparam logic [IOB_UART_HOST_DATA_W/8-1:0] IOB_UART_HOST_WSTRB_ALL = '1;

    localparam int DEF_SOFTRESET_ADDR = 0;
    localparam int DEF_DIV_ADDR       = 1;
    localparam int DEF_TXDATA_ADDR    = 2;
    localparam int DEF_TXEN_ADDR      = 3;
    localparam int DEF_TXREADY_ADDR   = 4;
    localparam int DEF_RXEN_ADDR      = 5;
    localparam int DEF_RXREADY_ADDR   = 6;
    localparam int DEF_RXDATA_ADDR    = 7;

endpackage

// File: rtl/iob_uart_host_txn.sv
// Single-transaction IOb initiator: holds a request until ready, then for
// reads waits for rvalid. done pulses combinationally on the completion cycle.
module iob_uart_host_txn #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                iob_valid,
    output logic [ADDR_W-1:0]   iob_addr,
    output logic [DATA_W-1:0]   iob_wdata,
    output logic [DATA_W/8-1:0] iob_wstrb,
    input  logic                iob_rvalid,
    input  logic [DATA_W-1:0]   iob_rdata,
    input  logic                iob_ready
);

    logic we_q;
    logic wait_rv;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iob_valid <= 1'b0;
            iob_addr  <= '0;
            iob_wdata <= '0;
            iob_wstrb <= '0;
            we_q      <= 1'b0;
            wait_rv   <= 1'b0;
        end else if (iob_valid) begin
            if (iob_ready) begin
                iob_valid <= 1'b0;
                wait_rv   <= !we_q && !iob_rvalid;
            end
        end else if (wait_rv) begin
            if (iob_rvalid) wait_rv <= 1'b0;
        end else if (start) begin
            iob_valid <= 1'b1;
            iob_addr  <= addr;
            iob_wdata <= we ? wdata : '0;
            iob_wstrb <= we ? '1 : '0;
            we_q      <= we;
        end
    end

    // A read may see rvalid on the accept cycle itself or any later cycle.
    assign done  = (iob_valid && iob_ready && (we_q || iob_rvalid)) || (wait_rv && iob_rvalid);
    assign rdata = iob_rdata;

endmodule

// File: rtl/iob_uart_host.sv
// IOb host that initialises the UART and feeds it bytes from a valid/ready
// stream. Optional RX service is compiled in with IOB_UART_HOST_RX_EN.
module iob_uart_host
    import iob_uart_host_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = IOB_UART_HOST_DATA_W,
    parameter int DIV_W          = 16,
    parameter int POLL_GAP       = 4,
    parameter int SOFTRESET_ADDR = DEF_SOFTRESET_ADDR,
    parameter int DIV_ADDR       = DEF_DIV_ADDR,
    parameter int TXDATA_ADDR    = DEF_TXDATA_ADDR,
    parameter int TXEN_ADDR      = DEF_TXEN_ADDR,
    parameter int TXREADY_ADDR   = DEF_TXREADY_ADDR,
    parameter int RXEN_ADDR      = DEF_RXEN_ADDR,
    parameter int RXREADY_ADDR   = DEF_RXREADY_ADDR,
    parameter int RXDATA_ADDR    = DEF_RXDATA_ADDR
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cfg_i,
    input  logic [DIV_W-1:0]    div_i,
    output logic                init_done_o,
    input  logic [7:0]          tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
`ifdef IOB_UART_HOST_RX_EN
    output logic [7:0]          rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
`endif
    output logic                iob_valid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i
);

    localparam int GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    state_t             state;
    logic               start;
    logic               cfg_pend;
    logic [GAP_W-1:0]   gap_cnt;
    logic               tx_full;
    logic [7:0]         tx_byte;
    logic               req_we;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic               done;
    logic [DATA_W-1:0]  rdata;
    logic               cfg_go;
    logic               wr_done;
    logic               unused_rdata;
`ifdef IOB_UART_HOST_RX_EN
    logic               tx_turn;
`else
    logic               unused_rx_addr;
    assign unused_rx_addr = ^{ADDR_W'(RXEN_ADDR), ADDR_W'(RXREADY_ADDR), ADDR_W'(RXDATA_ADDR)};
`endif

    assign cfg_go       = cfg_i || cfg_pend;
    assign wr_done      = done && (state == ST_WR_TX);
    assign unused_rdata = ^rdata;

    // The request is decoded from the state; start fires on the first cycle in a state,
    // so the DIV word carries div_i as seen at state entry.
    always_comb begin
        req_we    = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        case (state)
            ST_INIT_SRST1: begin req_addr = ADDR_W'(SOFTRESET_ADDR); req_wdata = DATA_W'(1); end
            ST_INIT_SRST0: begin req_addr = ADDR_W'(SOFTRESET_ADDR); end
            ST_INIT_DIV:   begin req_addr = ADDR_W'(DIV_ADDR);       req_wdata = DATA_W'(div_i); end
            ST_INIT_TXEN:  begin req_addr = ADDR_W'(TXEN_ADDR);      req_wdata = DATA_W'(1); end
            ST_POLL_TX:    begin req_addr = ADDR_W'(TXREADY_ADDR);   req_we = 1'b0; end
            ST_WR_TX:      begin req_addr = ADDR_W'(TXDATA_ADDR);    req_wdata = DATA_W'(tx_byte); end
`ifdef IOB_UART_HOST_RX_EN
            ST_INIT_RXEN:  begin req_addr = ADDR_W'(RXEN_ADDR);      req_wdata = DATA_W'(1); end
            ST_POLL_RX:    begin req_addr = ADDR_W'(RXREADY_ADDR);   req_we = 1'b0; end
            ST_RD_RX:      begin req_addr = ADDR_W'(RXDATA_ADDR);    req_we = 1'b0; end
`endif
            default:       req_we = 1'b1;
        endcase
    end

    // NOTE: tx_byte has no reset; tx_full alone says whether it holds anything.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_full    <= 1'b0;
            tx_ready_o <= 1'b0;
        end else if (wr_done) begin
            tx_full    <= 1'b0;
            tx_ready_o <= 1'b1;
        end else if (tx_valid_i && tx_ready_o) begin
            tx_full    <= 1'b1;
            tx_byte    <= tx_data_i;
            tx_ready_o <= 1'b0;
        end else begin
            tx_ready_o <= !tx_full;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= ST_INIT_SRST1;
            start       <= 1'b1;
            cfg_pend    <= 1'b0;
            gap_cnt     <= '0;
            init_done_o <= 1'b0;
`ifdef IOB_UART_HOST_RX_EN
            tx_turn     <= 1'b1;
            rx_valid_o  <= 1'b0;
            rx_data_o   <= '0;
`endif
        end else begin
            start <= 1'b0;
`ifdef IOB_UART_HOST_RX_EN
            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
            if (done && state == ST_RD_RX) begin
                rx_data_o  <= rdata[7:0];
                rx_valid_o <= 1'b1;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (cfg_i) begin
                        state <= ST_INIT_SRST1; start <= 1'b1; init_done_o <= 1'b0;
`ifdef IOB_UART_HOST_RX_EN
                    end else if (tx_full && (tx_turn || rx_valid_o)) begin
                        state <= ST_POLL_TX; start <= 1'b1; tx_turn <= 1'b0;
                    end else if (!rx_valid_o) begin
                        state <= ST_POLL_RX; start <= 1'b1; tx_turn <= 1'b1;
`else
                    end else if (tx_full) begin
                        state <= ST_POLL_TX; start <= 1'b1;
`endif
                    end
                end
                ST_GAP: begin
                    if (cfg_i) begin
                        state <= ST_INIT_SRST1; start <= 1'b1; init_done_o <= 1'b0;
                    end else if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    // Transaction states: a cfg request waits for the handshake to finish.
                    if (done) begin
                        cfg_pend <= 1'b0;
                        if (cfg_go) begin
                            state <= ST_INIT_SRST1; start <= 1'b1; init_done_o <= 1'b0;
                        end else begin
                            case (state)
                                ST_INIT_SRST1: begin state <= ST_INIT_SRST0; start <= 1'b1; end
                                ST_INIT_SRST0: begin state <= ST_INIT_DIV;   start <= 1'b1; end
                                ST_INIT_DIV:   begin state <= ST_INIT_TXEN;  start <= 1'b1; end
`ifdef IOB_UART_HOST_RX_EN
                                ST_INIT_TXEN:  begin state <= ST_INIT_RXEN;  start <= 1'b1; end
                                ST_INIT_RXEN:  begin state <= ST_IDLE; init_done_o <= 1'b1; tx_turn <= 1'b1; end
                                ST_POLL_RX: begin
                                    if (rdata[0]) begin
                                        state <= ST_RD_RX; start <= 1'b1;
                                    end else if (POLL_GAP == 0) begin
                                        state <= ST_IDLE;
                                    end else begin
                                        state <= ST_GAP; gap_cnt <= '0;
                                    end
                                end
`else
                                ST_INIT_TXEN:  begin state <= ST_IDLE; init_done_o <= 1'b1; end
`endif
                                ST_POLL_TX: begin
                                    if (rdata[0]) begin
                                        state <= ST_WR_TX; start <= 1'b1;
                                    end else if (POLL_GAP == 0) begin
                                        state <= ST_IDLE;
                                    end else begin
                                        state <= ST_GAP; gap_cnt <= '0;
                                    end
                                end
                                default: state <= ST_IDLE;
                            endcase
                        end
                    end else if (cfg_i) begin
                        cfg_pend <= 1'b1;
                    end
                end
            endcase
        end
    end

    iob_uart_host_txn #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_txn (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .start      (start),
        .we         (req_we),
        .addr       (req_addr),
        .wdata      (req_wdata),
        .done       (done),
        .rdata      (rdata),
        .iob_valid  (iob_valid_o),
        .iob_addr   (iob_addr_o),
        .iob_wdata  (iob_wdata_o),
        .iob_wstrb  (iob_wstrb_o),
        .iob_rvalid (iob_rvalid_i),
        .iob_rdata  (iob_rdata_i),
        .iob_ready  (iob_ready_i)
    );

endmodule

// File: tb/tb_iob_uart_host.sv
// Directed self-checking bench for iob_uart_host with a scripted IOb responder
// that logs every accepted TX-side request.
module tb_iob_uart_host;
    import iob_uart_host_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int DIV_W    = 16;
    localparam int POLL_GAP = 4;
    localparam int BUDGET   = 600;

    localparam logic [15:0] A_SRST   = 16'd0;
    localparam logic [15:0] A_DIV    = 16'd1;
    localparam logic [15:0] A_TXDATA = 16'd2;
    localparam logic [15:0] A_TXEN   = 16'd3;
    localparam logic [15:0] A_TXRDY  = 16'd4;
    localparam logic [15:0] A_RXEN   = 16'd5;
    localparam logic [15:0] A_RXRDY  = 16'd6;
    localparam logic [15:0] A_RXDATA = 16'd7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg;
    logic [DIV_W-1:0]  div;
    logic              init_done;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              iob_valid;
    logic [ADDR_W-1:0] iob_addr;
    logic [DATA_W-1:0] iob_wdata;
    logic [3:0]        iob_wstrb;
    logic              iob_rvalid;
    logic [DATA_W-1:0] iob_rdata;
    logic              iob_ready;
`ifdef IOB_UART_HOST_RX_EN
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          stall_n = 0;
    logic [15:0] stall_addr = '0;
    logic [31:0] txrdy_q[$];
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    int          rx_polls = 0;

    logic [15:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_wstrb[$];
    int          log_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iob_uart_host #(.POLL_GAP(POLL_GAP)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cfg_i        (cfg),
        .div_i        (div),
        .init_done_o  (init_done),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
`ifdef IOB_UART_HOST_RX_EN
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
`endif
        .iob_valid_o  (iob_valid),
        .iob_addr_o   (iob_addr),
        .iob_wdata_o  (iob_wdata),
        .iob_wstrb_o  (iob_wstrb),
        .iob_rvalid_i (iob_rvalid),
        .iob_rdata_i  (iob_rdata),
        .iob_ready_i  (iob_ready)
    );

    // Responder: decides ready/rvalid/rdata on the falling edge for the coming rising edge.
    initial begin
        iob_ready  = 1'b0;
        iob_rvalid = 1'b0;
        iob_rdata  = '0;
        forever begin
            @(negedge clk);
            iob_ready  = 1'b1;
            iob_rvalid = 1'b1;
            iob_rdata  = '0;
            if (iob_valid) begin
                if (stall_n > 0 && iob_addr == stall_addr) begin
                    iob_ready = 1'b0;
                    stall_n--;
                end else if (iob_addr == A_RXEN || iob_addr == A_RXRDY || iob_addr == A_RXDATA) begin
                    rx_polls++;
                    if (iob_addr == A_RXRDY) iob_rdata = {31'd0, rx_rdy};
                    if (iob_addr == A_RXDATA) iob_rdata = {24'd0, rx_byte};
                end else begin
                    if (iob_addr == A_TXRDY) iob_rdata = (txrdy_q.size() > 0) ? txrdy_q.pop_front() : 32'd1;
                    log_addr.push_back(iob_addr);
                    log_wdata.push_back(iob_wdata);
                    log_wstrb.push_back(iob_wstrb);
                    log_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_wstrb.delete();
        log_cyc.delete();
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (log_addr.size() < n && k < BUDGET) begin step(); k++; end
        check({tag, "_reached"}, 32'(log_addr.size() >= n), 32'd1);
    endtask

    task automatic wait_bus(input logic [15:0] a, input string tag);
        int k = 0;
        while (!(iob_valid && iob_addr == a) && k < BUDGET) begin step(); k++; end
        check({tag, "_seen"}, 32'(iob_valid && iob_addr == a), 32'd1);
    endtask

    task automatic wait_txrdy(input string tag);
        int k = 0;
        while (!tx_ready && k < BUDGET) begin step(); k++; end
        check({tag, "_txrdy"}, 32'(tx_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        wait_txrdy(tag);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    // Checks one logged request; a read is identified by an all-zero strobe.
    task automatic check_entry(input int i, input logic [15:0] a, input logic [31:0] wd,
                               input bit is_wr, input string tag);
        if (i < log_addr.size()) begin
            check({tag, "_addr"}, 32'(log_addr[i]), 32'(a));
            check({tag, "_wstrb"}, 32'(log_wstrb[i]), is_wr ? 32'(IOB_UART_HOST_WSTRB_ALL) : 32'd0);
            if (is_wr) check({tag, "_wdata"}, log_wdata[i], wd);
        end else begin
            check({tag, "_present"}, 32'(log_addr.size()), 32'(i + 1));
        end
    endtask

    initial begin
        logic prev_done;
        int   k;
        int   n_tx;
        rst_n = 1'b0; cfg = 1'b0; div = 16'd434; tx_data = 8'h00; tx_valid = 1'b0;
`ifdef IOB_UART_HOST_RX_EN
        rx_ready = 1'b0;
`endif
        repeat (3) step();

        // Reset values
        check("rst_valid", 32'(iob_valid), 32'd0);
        check("rst_addr", 32'(iob_addr), 32'd0);
        check("rst_wdata", iob_wdata, 32'd0);
        check("rst_wstrb", 32'(iob_wstrb), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Init sequence with div 434
        rst_n = 1'b1;
        step();
        check("tx_ready_after_rst", 32'(tx_ready), 32'd1);
        k = 0;
        prev_done = init_done;
        while (log_addr.size() < 4 && k < BUDGET) begin prev_done = init_done; step(); k++; end
        check("init_reached", 32'(log_addr.size() >= 4), 32'd1);
`ifndef IOB_UART_HOST_RX_EN
        check("init_done_before_txen", 32'(prev_done), 32'd0);
        check("init_done_after_txen", 32'(init_done), 32'd1);
`else
        k = 0;
        while (!init_done && k < BUDGET) begin step(); k++; end
        check("init_done_rx", 32'(init_done), 32'd1);
`endif
        check_entry(0, A_SRST, 32'd1, 1'b1, "init0");
        check_entry(1, A_SRST, 32'd0, 1'b1, "init1");
        check_entry(2, A_DIV, 32'd434, 1'b1, "init2");
        check_entry(3, A_TXEN, 32'd1, 1'b1, "init3");

        // Byte 0x55 with TXREADY replies 0, 0, 1
        clear_log();
        txrdy_q = {32'd0, 32'd0, 32'd1};
        send(8'h55, "b55");
        check("b55_hold_full", 32'(tx_ready), 32'd0);
        wait_log(4, "b55");
        check("b55_tx_ready_back", 32'(tx_ready), 32'd1);
        check_entry(0, A_TXRDY, 32'd0, 1'b0, "b55_poll0");
        check_entry(1, A_TXRDY, 32'd0, 1'b0, "b55_poll1");
        check_entry(2, A_TXRDY, 32'd0, 1'b0, "b55_poll2");
        check_entry(3, A_TXDATA, 32'h55, 1'b1, "b55_wr");
        if (log_cyc.size() >= 3) begin
            check("b55_gap0", 32'(log_cyc[1] - log_cyc[0] >= POLL_GAP + 1), 32'd1);
            check("b55_gap1", 32'(log_cyc[2] - log_cyc[1] >= POLL_GAP + 1), 32'd1);
        end

        // TXDATA write stalled 5 cycles while 0xA3 waits
        clear_log();
        stall_addr = A_TXDATA;
        stall_n = 5;
        send(8'h3C, "b3c");
        tx_data = 8'hA3;
        tx_valid = 1'b1;
        wait_bus(A_TXDATA, "stall");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(iob_valid), 32'd1);
            check("stall_addr", 32'(iob_addr), 32'(A_TXDATA));
            check("stall_wdata", iob_wdata, 32'h3C);
            check("stall_tx_ready", 32'(tx_ready), 32'd0);
            step();
        end
        wait_txrdy("a3");
        step();
        tx_valid = 1'b0;
        check_entry(1, A_TXDATA, 32'h3C, 1'b1, "b3c_wr");
        wait_log(4, "a3");
        check_entry(3, A_TXDATA, 32'hA3, 1'b1, "a3_wr");

        // cfg pulse during a stalled poll with 0x7E held; new divisor 100
        clear_log();
        div = 16'd100;
        stall_addr = A_TXRDY;
        stall_n = 3;
        send(8'h7E, "b7e");
        wait_bus(A_TXRDY, "cfg_poll");
        cfg = 1'b1;
        step();
        cfg = 1'b0;
        wait_log(2, "reinit");
        check("reinit_init_done", 32'(init_done), 32'd0);
        wait_log(7, "b7e");
        check_entry(0, A_TXRDY, 32'd0, 1'b0, "cfg_poll");
        check_entry(1, A_SRST, 32'd1, 1'b1, "reinit0");
        check_entry(2, A_SRST, 32'd0, 1'b1, "reinit1");
        check_entry(3, A_DIV, 32'd100, 1'b1, "reinit2");
        check_entry(4, A_TXEN, 32'd1, 1'b1, "reinit3");
        check_entry(5, A_TXRDY, 32'd0, 1'b0, "b7e_poll");
        check_entry(6, A_TXDATA, 32'h7E, 1'b1, "b7e_wr");

        // Reset while a poll is pending and unaccepted
        clear_log();
        stall_addr = A_TXRDY;
        stall_n = 20;
        send(8'h11, "b11");
        wait_bus(A_TXRDY, "rst_poll");
        rst_n = 1'b0;
        step();
        check("midrst_valid", 32'(iob_valid), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        step();
        stall_n = 0;
        clear_log();
        rst_n = 1'b1;
        wait_log(4, "rerst");
        check_entry(0, A_SRST, 32'd1, 1'b1, "rerst0");
        check_entry(3, A_TXEN, 32'd1, 1'b1, "rerst3");
        repeat (40) step();
        n_tx = 0;
        foreach (log_addr[i]) if (log_addr[i] == A_TXDATA) n_tx++;
        check("rerst_byte_dropped", 32'(n_tx), 32'd0);
        check("rerst_tx_ready", 32'(tx_ready), 32'd1);

`ifdef IOB_UART_HOST_RX_EN
        // RX byte 0xC4 held while the consumer is not ready
        rx_byte = 8'hC4;
        rx_rdy = 1'b1;
        k = 0;
        while (!rx_valid && k < BUDGET) begin step(); k++; end
        check("rx_valid", 32'(rx_valid), 32'd1);
        check("rx_data", 32'(rx_data), 32'hC4);
        rx_rdy = 1'b0;
        n_tx = rx_polls;
        clear_log();
        send(8'h99, "b99");
        wait_log(2, "b99");
        check_entry(1, A_TXDATA, 32'h99, 1'b1, "b99_wr");
        repeat (10) step();
        check("rx_no_polls", 32'(rx_polls), 32'(n_tx));
        check("rx_still_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("rx_valid_cleared", 32'(rx_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
